// File: rtl/attention_softmax.sv
// attention_softmax: row-wise softmax over a score matrix (max-subtract, LUT exp, restoring divide).
// Optional causal masking of keys k > query index when ATTENTION_SOFTMAX_CAUSAL_MASK_EN is defined.
module attention_softmax #(
  parameter int DATA_WIDTH = 16,
  parameter int L = 16,
  parameter int N = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [L*N*L-1:0][DATA_WIDTH-1:0]     A_in,
  output logic [L*N*L-1:0][DATA_WIDTH-1:0]     P_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 out_valid
);
  localparam int R  = L * N;
  localparam int T  = R * L;
  localparam int KW = L > 1 ? $clog2(L) : 1;
  localparam int RW = R > 1 ? $clog2(R) : 1;
  localparam int IW = T > 1 ? $clog2(T) : 1;
  localparam int SW = 16 + $clog2(L) + 1;

  typedef enum logic [2:0] {IDLE, MAX, EXP, DIV, DONE} st_t;

  // Elaboration-time round(65536*exp(-i/32)) via an integer Taylor series at 2^-50 resolution.
  function automatic logic [15:0] lut_val(input int i);
    longint term, acc;
    term = 64'sd1 <<< 50;
    acc  = term;
    for (int n = 1; n < 40; n++) begin
      term = -(term * longint'(i)) / longint'(32 * n);
      acc  = acc + term;
    end
    acc = (acc + (64'sd1 <<< 33)) >>> 34;
    return acc > 64'sd65535 ? 16'hFFFF : acc[15:0];
  endfunction

  logic [15:0] lut [64];
  for (genvar g = 0; g < 64; g++) begin : g_lut
    localparam logic [15:0] V = lut_val(g);
    assign lut[g] = V;
  end

  st_t                          st_q, st_d;
  logic [T-1:0][DATA_WIDTH-1:0] sb_q, sb_d, p_q, p_d;
  logic [L-1:0][15:0]           eb_q, eb_d;
  logic [RW-1:0]                r_q, r_d;
  logic [KW-1:0]                k_q, k_d;
  logic [4:0]                   c_q, c_d;
  logic signed [15:0]           m_q, m_d;
  logic [SW-1:0]                sum_q, sum_d, rem_q, rem_d, div_q, div_d;
  logic [15:0]                  qd_q, qd_d;

  logic [IW-1:0]      ei;
  logic signed [15:0] s;
  logic signed [16:0] d;
  logic [16:0]        nd;
  logic [15:0]        e, eo, qn;
  logic [SW:0]        t;
  logic               ge, msk, kl, rl;

  assign ei = IW'(r_q) * IW'(L) + IW'(k_q);
  assign s  = sb_q[ei];
  assign d  = {s[15], s} - {m_q[15], m_q};
  assign nd = -d;
`ifdef ATTENTION_SOFTMAX_CAUSAL_MASK_EN
  assign msk = int'(k_q) > int'(r_q) / N;
`else
  assign msk = 1'b0;
`endif
  assign e  = msk ? 16'd0 : lut[6'(nd >> 10)];
  assign kl = k_q == KW'(L - 1);
  assign rl = r_q == RW'(R - 1);
  assign eo = eb_q[k_q];
  // One restoring step: shift the next dividend bit into the partial remainder.
  assign t  = {rem_q, qd_q[15]};
  assign ge = t >= {1'b0, div_q};
  assign qn = {qd_q[14:0], ge};

  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = start ? MAX : IDLE;
      MAX:     st_d = kl ? EXP : MAX;
      EXP:     st_d = kl ? DIV : EXP;
      DIV:     st_d = (c_q == 5'd16 && kl) ? (rl ? DONE : MAX) : DIV;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = st_q != IDLE;
    done      = st_q == DONE;
    out_valid = done;
    P_out     = p_q;
  end

  always_comb begin
    sb_d  = sb_q;
    p_d   = p_q;
    eb_d  = eb_q;
    r_d   = r_q;
    k_d   = k_q;
    c_d   = c_q;
    m_d   = m_q;
    sum_d = sum_q;
    rem_d = rem_q;
    div_d = div_q;
    qd_d  = qd_q;
    case (st_q)
      IDLE: if (start) begin
        sb_d = A_in;
        r_d  = '0;
        k_d  = '0;
        c_d  = '0;
      end
      MAX: begin
        m_d = k_q == '0 ? s : (!msk && s > m_q) ? s : m_q;
        k_d = kl ? '0 : k_q + KW'(1);
      end
      EXP: begin
        eb_d[k_q] = e;
        sum_d     = k_q == '0 ? SW'(e) : sum_q + SW'(e);
        k_d       = kl ? '0 : k_q + KW'(1);
      end
      DIV: begin
        c_d = c_q == 5'd16 ? '0 : c_q + 5'd1;
        if (c_q == '0) begin
          rem_d = SW'(eo >> 1);
          qd_d  = {eo[0], 15'd0};
          div_d = sum_q;
        end else begin
          rem_d = ge ? SW'(t - {1'b0, div_q}) : t[SW-1:0];
          qd_d  = qn;
        end
        if (c_q == 5'd16) begin
          p_d[ei] = qn[15] ? 16'h7FFF : qn;
          k_d     = kl ? '0 : k_q + KW'(1);
          r_d     = (kl && !rl) ? r_q + RW'(1) : r_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q  <= '0;
      p_q   <= '0;
      eb_q  <= '0;
      r_q   <= '0;
      k_q   <= '0;
      c_q   <= '0;
      m_q   <= '0;
      sum_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      qd_q  <= '0;
    end else begin
      sb_q  <= sb_d;
      p_q   <= p_d;
      eb_q  <= eb_d;
      r_q   <= r_d;
      k_q   <= k_d;
      c_q   <= c_d;
      m_q   <= m_d;
      sum_q <= sum_d;
      rem_q <= rem_d;
      div_q <= div_d;
      qd_q  <= qd_d;
    end
  end
endmodule

// File: doc/attention_softmax.md
Name: attention_softmax

Overview:
- Row-wise softmax stage directly downstream of the attention-score stage.
- Consumes the scaled score matrix A (L*N*L entries, signed Q1.15) and produces probabilities P (unsigned Q1.15); each row of L key scores sums to about 1.0.
- Uses max-subtraction, a LUT exponential, an accumulated row sum, and a sequential restoring divider.
- Feeds the attention-value (P*V) stage using the same start/done/out_valid whole-matrix handshake.

Parameters:
- DATA_WIDTH, 16, score/probability width (Q1.15); only 16 is supported.
- L, 16, sequence length; row length and query count.
- N, 1, batch/head count; number of rows R = L*N.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset; sampled on posedge clk only.
- start  input  1  start pulse; accepted only in IDLE.
- A_in  input  DATA_WIDTH x L*N*L  signed Q1.15 scores; index i*N*L + j*L + k (query i, batch j, key k).
- P_out  output  DATA_WIDTH x L*N*L  Q1.15 probabilities, same indexing; registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in DONE.
- out_valid  output  1  equals done.

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; P_out all 0; done=out_valid=busy=0; all counters, max, sum and divider registers cleared. Reset mid-operation aborts immediately, and no done is produced.
- States: IDLE, MAX, EXP, DIV, DONE. Row counter r runs 0..R-1; element counter k runs 0..L-1.
- IDLE: when start=1, capture all of A_in into an internal score buffer, set r=0, k=0, go to MAX. A_in may change after the start cycle.
- start while busy is ignored; there is no queuing.
- MAX (L cycles): one element per cycle; m = running signed max of row r. Then go to EXP.
- EXP (L cycles), one element per cycle:
  - d = s - m, 17-bit signed, range [-65535, 0].
  - idx = (-d) >> 10, range 0..63.
  - e = LUT[idx], where LUT[i] = min(65535, round(65536*exp(-i/32))), 16-bit unsigned. Examples: LUT[0]=65535, LUT[32]=24109.
  - Store e in the row exp buffer and accumulate sum (width 16+$clog2(L)+1; cannot overflow). sum is cleared at row start. Then go to DIV.
- DIV (17 cycles per element, L elements):
  - 1 setup cycle loads dividend e<<15 and divisor sum.
  - 16 restoring iterations produce q = floor(e*32768/sum).
  - P_out[r*L+k] = min(q, 32767), written at the end of the element.
  - After the last element: if r<R-1, increment r and go to MAX; else go to DONE.
- DONE: done=out_valid=1 for one cycle, then IDLE. P_out holds until the next accepted start or reset.
- Latency: with the start cycle as cycle 0, done is high in cycle R*19*L + 1. The total cycle count is data-independent.
- P_out entries update progressively during DIV and are meaningful only from done onward.
- sum > 0 is guaranteed because the max element always yields LUT[0].

Optional Feature:
- Macro: ATTENTION_SOFTMAX_CAUSAL_MASK_EN.
- Defined: for row r, the query index is i = r / N, and keys k > i are masked.
  - MAX ignores masked elements.
  - EXP forces e=0 for masked elements; they contribute nothing to sum.
  - DIV still spends 17 cycles on masked elements and writes P=0.
  - Latency is unchanged.
- Undefined: no masking; all L keys participate.

Test Plan:
1. L=16,N=1, all scores 0x0000: every e=65535 and sum=1048560, so every P_out = 2048; done high in cycle 4865; out_valid a single-cycle pulse coincident with done.
2. Row 0: A[0]=0x0000, A[1..15]=0x8000 (d=-32768, idx=32, e=24109); sum=427170 -> P[0]=5027, P[1..15]=1849. Other rows all zero -> 2048.
3. start asserted again at cycles 10 and 4000 -> ignored; exactly one done at 4865. A_in changed after cycle 0 -> results unchanged.
4. rst_n low at cycle 2000 -> next cycle busy=0, P_out all 0, no done. A new start afterwards -> done exactly 4865 cycles after the new start cycle.
5. Macro defined, L=16,N=1, all scores 0: row 0 -> P[0]=32767 (saturated from 32768), others 0. Row 1 -> P[16]=P[17]=16384, rest 0. Row 15 -> all 2048. Latency still 4865.
6. Alternate all-0x7FFF / all-0x8000 rows -> every P_out 2048; confirms max-subtraction removes the per-row offset.
